msg_schedule: RTL and testbench
===============================

MSG_SCHEDULE -- requirements
Module: msg_schedule

Interface
REQ-001 Parameter: none; round count fixed by mode (64 for SHA-256, 80 for SHA-512).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to expand a new message block; sampled only in IDLE.
REQ-005 mode  input  1  1 = SHA-512 (64-bit words), 0 = SHA-256 (32-bit words); latched on accepted start.
REQ-006 block_in  input  1024  message block; SHA-512 word j = block_in[1023-64j -: 64]; SHA-256 word j = block_in[511-32j -: 32], bits [1023:512] ignored.
REQ-007 hold  input  1  stall; when high in RUN, all state and outputs freeze.
REQ-008 W  output  64  current schedule word W_t; SHA-256 values zero-extended ({32'h0, w32}).
REQ-009 w_valid  output  1  W and round valid this cycle (high in RUN).
REQ-010 round  output  7  index t of W currently presented.
REQ-011 init  output  1  high while round==0 and w_valid (first word of block).
REQ-012 last  output  1  high while w_valid and round==N-1.
REQ-013 done  output  1  single-cycle pulse after the last word is consumed.
REQ-014 busy  output  1  high in RUN and FIN.

Function
REQ-015 FSM states SHALL be IDLE, RUN, FIN; IDLE->RUN on start; RUN->FIN when last && !hold; FIN->IDLE unconditionally.
REQ-016 On accepted start, the 16 block words SHALL load into a 16-entry shift register (entry 0 = W_0) and round SHALL clear to 0; W_0 is presented in the first RUN cycle (latency 1).
REQ-017 Each RUN cycle with hold low SHALL shift entry k <= entry k+1 and load entry 15 <= σ1(e14) + e9 + σ0(e1) + e0, and SHALL increment round.
REQ-018 Addition SHALL wrap modulo 2^32 (SHA-256) or 2^64 (SHA-512); upper 32 bits of every SHA-256 entry SHALL stay zero.
REQ-019 SHA-256: σ0 = ROTR7^ROTR18^SHR3, σ1 = ROTR17^ROTR19^SHR10; SHA-512: σ0 = ROTR1^ROTR8^SHR7, σ1 = ROTR19^ROTR61^SHR6.
REQ-020 W SHALL equal entry 0; outside RUN, W SHALL be 0 and w_valid, init, last low.
REQ-021 start while busy SHALL be ignored; start in FIN is not accepted (next start needs IDLE).
REQ-022 hold high in IDLE or FIN SHALL have no effect; hold high on the last cycle SHALL delay FIN.
REQ-023 mode and block_in changes while busy SHALL have no effect.
REQ-024 done SHALL be high only in FIN (exactly one cycle per block).

Reset
REQ-025 rst_n low SHALL immediately force IDLE, round=0, all shift entries 0, W=0, w_valid=init=last=done=busy=0, including mid-block.
REQ-026 After release, first start SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-027 Macro SHA512_EN: defined -> both modes supported as above; undefined -> mode input ignored, SHA-256 only, entries 32-bit, N fixed at 64, W zero-extended to 64 bits.

Structure
REQ-028 Shared package sha_pkg SHALL hold mode encodings, round counts (64/80), word widths and FSM state typedef.
REQ-029 Sub-module msg_sigma SHALL implement σ0/σ1 combinationally for both modes.

Verification
REQ-030 SHA-256 "abc" block (W0=0x61626380, W15=0x00000018, rest 0), start pulse -> next cycle init=1, W=0x0000000061626380; round 16 W=0x61626380; round 17 W=0x000F0000.
REQ-031 SHA-256 run without hold -> last at round 63, done exactly 64 cycles after first w_valid cycle, busy low the cycle after done.
REQ-032 SHA-512 all-zero block -> 80 W words all 0, last at round 79, done one cycle later.
REQ-033 hold high for 3 cycles at round 20 -> W and round unchanged for 3 cycles, done delayed by 3 cycles.
REQ-034 start pulsed at round 30 and in FIN -> ignored; second block starts only from IDLE.
REQ-035 rst_n asserted at round 40 -> outputs 0 asynchronously, state IDLE; new start behaves as REQ-030.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared SHA-2 message schedule definitions: mode encodings, round counts, word widths, FSM states.
// Entry width follows the SHA512_EN macro (64-bit entries when defined, 32-bit otherwise).
package sha_pkg;

    localparam logic MODE_SHA256 = 1'b0;
    localparam logic MODE_SHA512 = 1'b1;

    localparam logic [6:0] ROUNDS_SHA256 = 7'd64;
    localparam logic [6:0] ROUNDS_SHA512 = 7'd80;

    localparam int WORD_W_SHA256 = 32;
    localparam int WORD_W_SHA512 = 64;

`ifdef SHA512_EN
    localparam int ENTRY_W = WORD_W_SHA512;
`else
    localparam int ENTRY_W = WORD_W_SHA256;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/msg_sigma.sv
// Combinational small-sigma functions for the SHA-256 and SHA-512 message schedule.
// SHA-256 results are zero-extended to 64 bits.
module msg_sigma
    import sha_pkg::*;
(
    input  logic        mode,
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    output logic [63:0] sigma0,
    output logic [63:0] sigma1
);

    logic [31:0] s0_256;
    logic [31:0] s1_256;
    logic [63:0] s0_512;
    logic [63:0] s1_512;

    always_comb begin
        s0_256 = rotr32(x0[31:0], 7)  ^ rotr32(x0[31:0], 18) ^ (x0[31:0] >> 3);
        s1_256 = rotr32(x1[31:0], 17) ^ rotr32(x1[31:0], 19) ^ (x1[31:0] >> 10);
        s0_512 = rotr64(x0, 1)  ^ rotr64(x0, 8)  ^ (x0 >> 7);
        s1_512 = rotr64(x1, 19) ^ rotr64(x1, 61) ^ (x1 >> 6);
    end

    assign sigma0 = (mode == MODE_SHA512) ? s0_512 : {32'h0, s0_256};
    assign sigma1 = (mode == MODE_SHA512) ? s1_512 : {32'h0, s1_256};

endmodule

// File: rtl/msg_schedule.sv
// SHA-2 message schedule expander: streams W_0..W_{N-1} from a 16-entry shift register.
// SHA512_EN defined -> SHA-256 and SHA-512 selectable by mode; undefined -> SHA-256 only.
module msg_schedule
    import sha_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [1023:0] block_in,
    input  logic          hold,
    output logic [63:0]   W,
    output logic          w_valid,
    output logic [6:0]    round,
    output logic          init,
    output logic          last,
    output logic          done,
    output logic          busy
);

    state_t             state;
    logic [ENTRY_W-1:0] sched [16];
    logic [6:0]         round_q;
    logic               mode_q;
    logic               eff_mode;
    logic [6:0]         last_round;
    logic [63:0]        sigma0;
    logic [63:0]        sigma1;
    logic [63:0]        sum;
    logic [63:0]        next_word;

`ifdef SHA512_EN
    assign eff_mode = mode;
`else
    logic unused_bits;
    assign eff_mode    = MODE_SHA256;
    assign unused_bits = ^{mode, block_in[1023:512], next_word[63:32]};
`endif

    msg_sigma u_sigma (
        .mode   (mode_q),
        .x0     (64'(sched[1])),
        .x1     (64'(sched[14])),
        .sigma0 (sigma0),
        .sigma1 (sigma1)
    );

    // SHA-256 words must keep their upper half clear so the modulo-2^32 wrap holds.
    assign sum        = sigma1 + 64'(sched[9]) + sigma0 + 64'(sched[0]);
    assign next_word  = (mode_q == MODE_SHA512) ? sum : {32'h0, sum[31:0]};
    assign last_round = (mode_q == MODE_SHA512) ? ROUNDS_SHA512 - 7'd1 : ROUNDS_SHA256 - 7'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            round_q <= '0;
            mode_q  <= MODE_SHA256;
            for (int k = 0; k < 16; k++) sched[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q  <= eff_mode;
                        round_q <= '0;
                        state   <= RUN;
                        for (int j = 0; j < 16; j++) begin
`ifdef SHA512_EN
                            sched[j] <= (eff_mode == MODE_SHA512) ? block_in[1023-64*j -: 64]
                                                                  : {32'h0, block_in[511-32*j -: 32]};
`else
                            sched[j] <= block_in[511-32*j -: 32];
`endif
                        end
                    end
                end
                RUN: begin
                    if (!hold) begin
                        for (int k = 0; k < 15; k++) sched[k] <= sched[k+1];
                        sched[15] <= next_word[ENTRY_W-1:0];
                        if (round_q == last_round) state <= FIN;
                        else round_q <= round_q + 7'd1;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign w_valid = (state == RUN);
    assign W       = w_valid ? 64'(sched[0]) : 64'h0;
    assign round   = w_valid ? round_q : 7'd0;
    assign init    = w_valid && (round_q == 7'd0);
    assign last    = w_valid && (round_q == last_round);
    assign done    = (state == FIN);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_msg_schedule.sv
// Self-checking bench for msg_schedule against a recurrence-based SHA-2 schedule model.
// Honours SHA512_EN: without it every block is expected to expand as SHA-256.
`timescale 1ns/1ps
module tb_msg_schedule;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          hold = 1'b0;
    logic [1023:0] block_in = '0;
    logic [63:0]   W;
    logic          w_valid;
    logic [6:0]    round;
    logic          init;
    logic          last;
    logic          done;
    logic          busy;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [63:0]   exp_w [80];
    int            exp_n = 64;

    always #5 clk = ~clk;

    msg_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .block_in (block_in),
        .hold     (hold),
        .W        (W),
        .w_valid  (w_valid),
        .round    (round),
        .init     (init),
        .last     (last),
        .done     (done),
        .busy     (busy)
    );

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] rot(input logic [63:0] x, input int n, input int width);
        logic [127:0] d;
        if (width == 32) begin
            d = {64'h0, x[31:0], x[31:0]};
            return {32'h0, d[n +: 32]};
        end
        d = {x, x};
        return d[n +: 64];
    endfunction

    // Reference: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
    task automatic build_model(input logic m, input logic [1023:0] blk);
        logic        eff;
        logic [63:0] a, b, s0, s1, total;
`ifdef SHA512_EN
        eff = m;
`else
        eff = 1'b0;
`endif
        exp_n = eff ? 80 : 64;
        for (int t = 0; t < 16; t++)
            exp_w[t] = eff ? blk[1023-64*t -: 64] : {32'h0, blk[511-32*t -: 32]};
        for (int t = 16; t < exp_n; t++) begin
            a = exp_w[t-15];
            b = exp_w[t-2];
            if (eff) begin
                s0 = rot(a, 1, 64) ^ rot(a, 8, 64) ^ (a >> 7);
                s1 = rot(b, 19, 64) ^ rot(b, 61, 64) ^ (b >> 6);
            end else begin
                s0 = rot(a, 7, 32) ^ rot(a, 18, 32) ^ (a >> 3);
                s1 = rot(b, 17, 32) ^ rot(b, 19, 32) ^ (b >> 10);
            end
            total = s1 + exp_w[t-7] + s0 + exp_w[t-16];
            exp_w[t] = eff ? total : (total & 64'hFFFF_FFFF);
        end
    endtask

    task automatic rand_block(output logic [1023:0] b);
        for (int i = 0; i < 32; i++) b[i*32 +: 32] = $urandom;
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_w"},       W, 64'h0);
        check_output({tag, "_valid"},   64'(w_valid), 64'h0);
        check_output({tag, "_busy"},    64'(busy), 64'h0);
        check_output({tag, "_done"},    64'(done), 64'h0);
        check_output({tag, "_round"},   64'(round), 64'h0);
    endtask

    // Called at a negedge; start is presented immediately and accepted on the next rising edge.
    task automatic apply_stimulus(input logic m, input logic [1023:0] blk, input int hold_at,
                                  input int hold_len, input int poke_at, input int abort_at);
        int            t;
        int            held;
        logic [1023:0] junk;
        build_model(m, blk);
        mode = m;
        block_in = blk;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rand_block(junk);
        block_in = junk;
        mode = ~m;
        t = 0;
        held = 0;
        while (t < exp_n) begin
            check_output($sformatf("w_r%0d", t), W, exp_w[t]);
            check_output($sformatf("round_r%0d", t), 64'(round), 64'(t));
            check_output("w_valid", 64'(w_valid), 64'h1);
            check_output("init", 64'(init), 64'(t == 0));
            check_output("last", 64'(last), 64'(t == exp_n - 1));
            check_output("busy_run", 64'(busy), 64'h1);
            check_output("done_run", 64'(done), 64'h0);
            if (t == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_idle("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
                hold = 1'b0;
                start = 1'b0;
                return;
            end
            start = (t == poke_at);
            if (t == hold_at && held < hold_len) begin
                hold = 1'b1;
                held++;
            end else begin
                hold = 1'b0;
                t++;
            end
            @(negedge clk);
        end
        hold = 1'b1;
        start = 1'b1;
        check_output("done_fin", 64'(done), 64'h1);
        check_output("busy_fin", 64'(busy), 64'h1);
        check_output("valid_fin", 64'(w_valid), 64'h0);
        check_output("w_fin", W, 64'h0);
        check_output("last_fin", 64'(last), 64'h0);
        @(negedge clk);
        start = 1'b0;
        hold = 1'b0;
        check_idle("after_fin");
        @(negedge clk);
        check_idle("still_idle");
    endtask

    initial begin
        logic [1023:0] abc;
        logic [1023:0] rb;
        int            h_at;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        abc = '0;
        abc[511 -: 32] = 32'h6162_6380;
        abc[31:0]      = 32'h0000_0018;
        $display("[TB] abc block, SHA-256");
        apply_stimulus(1'b0, abc, -1, 0, -1, -1);

        $display("[TB] all-zero block, SHA-512 request");
        apply_stimulus(1'b1, '0, -1, 0, -1, -1);

        $display("[TB] hold at round 20, start poked at round 30");
        apply_stimulus(1'b0, abc, 20, 3, 30, -1);

        $display("[TB] reset at round 40, then abc again");
        apply_stimulus(1'b0, abc, -1, 0, -1, 40);
        apply_stimulus(1'b0, abc, -1, 0, -1, -1);

        $display("[TB] hold on the last SHA-256 round");
        rand_block(rb);
        apply_stimulus(1'b0, rb, 63, 2, -1, -1);

        for (int i = 0; i < 4; i++) begin
            rand_block(rb);
            h_at = $urandom_range(0, 60);
            $display("[TB] random block %0d", i);
            apply_stimulus(1'($urandom_range(0, 1)), rb, h_at, $urandom_range(1, 4), h_at + 3, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
